// File: rtl/sram_mc_arb.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mc_arb
//  Purpose  : Multi-channel synchronous SRAM. NUM_CH requesters share one
//             storage array through a round-robin arbiter. Each channel has a
//             valid/ready request handshake, byte-enabled writes, a fixed
//             response latency of RSP_LAT cycles and out-of-range error
//             reporting.
//  Ports    : clk        - single clock, rising edge
//             reset_n    - synchronous active-low reset
//             req_valid  - per-channel request valid        [NUM_CH]
//             req_ready  - per-channel grant, one-hot/zero  [NUM_CH]
//             req_we     - per-channel write (1) / read (0) [NUM_CH]
//             req_addr   - packed addresses                 [NUM_CH*ADDR_W]
//             req_wdata  - packed write data                [NUM_CH*DATA_W]
//             req_be     - packed byte enables              [NUM_CH*DATA_W/8]
//             rsp_valid  - per-channel response pulse       [NUM_CH]
//             rsp_rdata  - packed read data                 [NUM_CH*DATA_W]
//             rsp_err    - per-channel out-of-range flag    [NUM_CH]
//  Revision : 1.0 - initial release
// ============================================================================
module sram_mc_arb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int DEPTH   = 48,
  parameter int NUM_CH  = 2,
  parameter int RSP_LAT = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            req_we,
  input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
  input  logic [NUM_CH*DATA_W-1:0]     req_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0]   req_be,
  output logic [NUM_CH-1:0]            rsp_valid,
  output logic [NUM_CH*DATA_W-1:0]     rsp_rdata,
  output logic [NUM_CH-1:0]            rsp_err
);

  localparam int              BE_W      = DATA_W / 8;
  localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int              MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              in_range;
  logic [MEM_AW-1:0] mem_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  // --------------------------------------------------------------------------
  // Round-robin search starting at rr_ptr+1. Iterating the offset downward
  // and overwriting leaves the smallest offset (highest priority) as winner.
  // --------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = rr_ptr;
    grant_any = 1'b0;
    for (int off = NUM_CH; off >= 1; off--) begin
      idx = (int'(rr_ptr) + off) % NUM_CH;
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept    = reset_n && grant_any;
  assign sel_we    = req_we[grant_idx];
  assign sel_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[grant_idx*DATA_W +: DATA_W];
  assign sel_be    = req_be[grant_idx*BE_W +: BE_W];
  assign in_range  = {1'b0, sel_addr} < DEPTH_LIM;
  assign mem_idx   = MEM_AW'(sel_addr);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr <= CH_W'(NUM_CH - 1);
    end else if (accept) begin
      rr_ptr <= grant_idx;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && sel_we && in_range) begin
      for (int k = 0; k < BE_W; k++) begin
        if (sel_be[k]) begin
          mem[mem_idx][k*8 +: 8] <= sel_wdata[k*8 +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response pipeline. Stage 0 captures the access at the accepting edge;
  // later stages only add delay. The last stage drives the outputs, so a
  // reset flushes everything still in flight.
  // --------------------------------------------------------------------------
  logic              pipe_vld  [RSP_LAT];
  logic [CH_W-1:0]   pipe_ch   [RSP_LAT];
  logic              pipe_err  [RSP_LAT];
  logic [DATA_W-1:0] pipe_data [RSP_LAT];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < RSP_LAT; s++) begin
        pipe_vld[s]  <= 1'b0;
        pipe_ch[s]   <= '0;
        pipe_err[s]  <= 1'b0;
        pipe_data[s] <= '0;
      end
    end else begin
      pipe_vld[0]  <= accept;
      pipe_ch[0]   <= grant_idx;
      pipe_err[0]  <= accept && !in_range;
      pipe_data[0] <= (accept && !sel_we && in_range) ? mem[mem_idx] : '0;
      for (int s = 1; s < RSP_LAT; s++) begin
        pipe_vld[s]  <= pipe_vld[s-1];
        pipe_ch[s]   <= pipe_ch[s-1];
        pipe_err[s]  <= pipe_err[s-1];
        pipe_data[s] <= pipe_data[s-1];
      end
    end
  end

  // Fan the single in-order response out to its channel; others read zero.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_rsp
    logic hit;
    assign hit                          = pipe_vld[RSP_LAT-1] &&
                                          (pipe_ch[RSP_LAT-1] == CH_W'(i));
    assign rsp_valid[i]                 = hit;
    assign rsp_err[i]                   = hit && pipe_err[RSP_LAT-1];
    assign rsp_rdata[i*DATA_W +: DATA_W] = hit ? pipe_data[RSP_LAT-1] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_mc_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_mc_arb
//  Purpose  : Directed self-checking bench for sram_mc_arb. Instance "a" uses
//             the default parameters (RSP_LAT = 1); instance "b" uses
//             RSP_LAT = 2 for the latency and reset-flush scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_mc_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a (RSP_LAT = 1)
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [11:0] req_addr;
  logic [63:0] req_wdata, rsp_rdata;
  logic [7:0]  req_be;

  // Instance b (RSP_LAT = 2)
  logic        reset_b;
  logic [1:0]  req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_err_b;
  logic [11:0] req_addr_b;
  logic [63:0] req_wdata_b, rsp_rdata_b;
  logic [7:0]  req_be_b;

  int checks = 0;
  int errors = 0;

  sram_mc_arb #(.DATA_W(32), .ADDR_W(6), .DEPTH(48), .NUM_CH(2), .RSP_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  sram_mc_arb #(.DATA_W(32), .ADDR_W(6), .DEPTH(48), .NUM_CH(2), .RSP_LAT(2)) dut_b (
    .clk(clk), .reset_n(reset_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_be(req_be_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input int ch, input logic we, input logic [5:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
    req_valid[ch]          = 1'b1;
    req_we[ch]             = we;
    req_addr[ch*6 +: 6]    = addr;
    req_wdata[ch*32 +: 32] = wd;
    req_be[ch*4 +: 4]      = be;
  endtask

  task automatic drive_b(input int ch, input logic we, input logic [5:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
    req_valid_b[ch]          = 1'b1;
    req_we_b[ch]             = we;
    req_addr_b[ch*6 +: 6]    = addr;
    req_wdata_b[ch*32 +: 32] = wd;
    req_be_b[ch*4 +: 4]      = be;
  endtask

  // Single-channel request on instance a: check the grant, pass the
  // accepting edge, leave the bench at edge+1 with valid dropped.
  task automatic acc_a(input string tag, input int ch, input logic we,
                       input logic [5:0] addr, input logic [31:0] wd,
                       input logic [3:0] be);
    req_valid = '0;
    drive_a(ch, we, addr, wd, be);
    #1 chk({tag, "_ready"}, req_ready, 64'(2'b01 << ch));
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  initial begin
    reset_n = 1'b0; reset_b = 1'b0;
    req_valid = 2'b11; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    req_valid_b = '0; req_we_b = '0; req_addr_b = '0; req_wdata_b = '0; req_be_b = '0;

    // Reset: ready forced low even with requests pending, outputs zero.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_b_ready", req_ready_b, 0);
    reset_n = 1'b1; reset_b = 1'b1; req_valid = '0;

    // Write then read address 5 on ch0.
    acc_a("wr5", 0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    chk("wr5_rsp_valid", rsp_valid, 2'b01);
    chk("wr5_rsp_rdata", rsp_rdata, 0);
    chk("wr5_rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    chk("idle_rsp_valid", rsp_valid, 0);
    acc_a("rd5", 0, 1'b0, 6'd5, 32'h0, 4'h0);
    chk("rd5_rsp_valid", rsp_valid, 2'b01);
    chk("rd5_rsp_rdata", rsp_rdata, 64'h0000_0000_DEAD_BEEF);
    chk("rd5_rsp_err", rsp_err, 0);

    // Partial byte-enable write.
    acc_a("wr7a", 0, 1'b1, 6'd7, 32'h11223344, 4'hF);
    acc_a("wr7b", 0, 1'b1, 6'd7, 32'hAABBCCDD, 4'h5);
    acc_a("rd7", 0, 1'b0, 6'd7, 32'h0, 4'h0);
    chk("rd7_rsp_rdata", rsp_rdata, 64'h0000_0000_11BB_33DD);

    // Read-after-write on consecutive cycles.
    acc_a("wr3", 0, 1'b1, 6'd3, 32'h0000_00A5, 4'hF);
    chk("wr3_rsp_valid", rsp_valid, 2'b01);
    acc_a("rd3", 0, 1'b0, 6'd3, 32'h0, 4'h0);
    chk("rd3_rsp_rdata", rsp_rdata, 64'h0000_0000_0000_00A5);

    // Ch1 boundary addresses: 47 legal, 48 and 50 out of range.
    acc_a("wr47", 1, 1'b1, 6'd47, 32'h12345678, 4'hF);
    chk("wr47_rsp_valid", rsp_valid, 2'b10);
    chk("wr47_rsp_err", rsp_err, 0);
    acc_a("rd47", 1, 1'b0, 6'd47, 32'h0, 4'h0);
    chk("rd47_rsp_err", rsp_err, 0);
    chk("rd47_rsp_rdata", rsp_rdata, 64'h1234_5678_0000_0000);
    acc_a("wr48", 1, 1'b1, 6'd48, 32'hFFFFFFFF, 4'hF);
    chk("wr48_rsp_err", rsp_err, 2'b10);
    acc_a("wr50", 1, 1'b1, 6'd50, 32'hCAFEF00D, 4'hF);
    chk("wr50_rsp_valid", rsp_valid, 2'b10);
    chk("wr50_rsp_err", rsp_err, 2'b10);
    chk("wr50_rsp_rdata", rsp_rdata, 0);
    acc_a("rd50", 1, 1'b0, 6'd50, 32'h0, 4'h0);
    chk("rd50_rsp_err", rsp_err, 2'b10);
    chk("rd50_rsp_rdata", rsp_rdata, 0);
    // Legal address 47 must not have been disturbed by the error writes.
    acc_a("rd47b", 1, 1'b0, 6'd47, 32'h0, 4'h0);
    chk("rd47b_rsp_rdata", rsp_rdata, 64'h1234_5678_0000_0000);

    // Re-reset, then both channels request continuously: grants alternate
    // starting with ch0 (pointer wraps 1 -> 0 each pair).
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive_a(0, 1'b0, 6'd5, 32'h0, 4'h0);
    drive_a(1, 1'b0, 6'd7, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("rr%0d_ready", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      chk($sformatf("rr%0d_rsp_valid", k), rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr%0d_rsp_rdata", k), rsp_rdata,
          (k % 2 == 0) ? 64'h0000_0000_DEAD_BEEF : 64'h11BB_33DD_0000_0000);
    end
    req_valid = '0;
    @(posedge clk); #1;
    chk("rr_done_rsp_valid", rsp_valid, 0);

    // Instance b: two-cycle latency.
    drive_b(0, 1'b1, 6'd1, 32'h55AA55AA, 4'hF);
    #1 chk("b_wr_ready", req_ready_b, 2'b01);
    @(posedge clk); #1;
    req_valid_b = '0;
    chk("b_wr_lat1_rsp_valid", rsp_valid_b, 0);
    @(posedge clk); #1;
    chk("b_wr_lat2_rsp_valid", rsp_valid_b, 2'b01);
    chk("b_wr_lat2_rsp_rdata", rsp_rdata_b, 0);
    @(posedge clk); #1;
    chk("b_wr_after_rsp_valid", rsp_valid_b, 0);

    // Instance b: reset while a read response is in flight drops it.
    drive_b(0, 1'b0, 6'd1, 32'h0, 4'h0);
    #1 chk("b_rd_ready", req_ready_b, 2'b01);
    @(posedge clk); #1;
    req_valid_b = '0;
    reset_b     = 1'b0;
    @(posedge clk); #1;
    chk("b_flush_rsp_valid", rsp_valid_b, 0);
    chk("b_flush_rsp_rdata", rsp_rdata_b, 0);
    chk("b_flush_rsp_err", rsp_err_b, 0);
    @(posedge clk); #1;
    chk("b_flush2_rsp_valid", rsp_valid_b, 0);
    reset_b     = 1'b1;
    req_valid_b = 2'b11;
    #1 chk("b_post_rst_ready", req_ready_b, 2'b01);
    @(posedge clk); #1;
    req_valid_b = '0;
    @(posedge clk); #1;
    chk("b_post_rst_rsp_valid", rsp_valid_b, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
